// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver for the stopwatch, shown as MM.SS.
// Binary minutes/seconds are synchronised, snapshotted once per scan frame,
// split into BCD digit pairs and scanned with a blank cycle at every slot start.
// In adjust mode the selected digit pair blinks.
module stopwatch_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_DIV    = 25000000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Scan slots in display order from the right; slot index doubles as digit position.
  typedef enum logic [1:0] {
    SLOT_SEC_ONES = 2'd0,
    SLOT_SEC_TENS = 2'd1,
    SLOT_MIN_ONES = 2'd2,
    SLOT_MIN_TENS = 2'd3
  } slot_t;

  slot_t slot_q, slot_d;

  logic [5:0]    mins_m, mins_s, secs_m, secs_s;
  logic          adj_m, adj_s, sel_m, sel_s;
  logic [RW-1:0] rcnt;
  logic          tick;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic [5:0]    snap_min, snap_sec;
  logic          load_pending;

  logic [5:0] val;
  logic       illegal;
  logic [3:0] digit;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       hide;
  logic       blank;

  // Binary -> BCD for values 0..59; callers handle 60..63 separately.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // Active-high segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Two-flop synchronisers; left unreset so they carry live values through reset.
  always_ff @(posedge clk) begin
    mins_m <= mins;
    mins_s <= mins_m;
    secs_m <= secs;
    secs_s <= secs_m;
    adj_m  <= adj;
    adj_s  <= adj_m;
    sel_m  <= sel;
    sel_s  <= sel_m;
  end

  // Refresh divider: one tick per digit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rcnt <= '0;
    else if (tick) rcnt <= '0;
    else           rcnt <= rcnt + 1'b1;
  end

  assign tick  = (rcnt == RW'(REFRESH_DIV - 1));
  assign blank = (rcnt == '0);

  // Slot index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= SLOT_SEC_ONES;
    else     slot_q <= slot_d;
  end

  // Slot sequencing: advance on each refresh tick, wrapping after minutes tens.
  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      case (slot_q)
        SLOT_SEC_ONES: slot_d = SLOT_SEC_TENS;
        SLOT_SEC_TENS: slot_d = SLOT_MIN_ONES;
        SLOT_MIN_ONES: slot_d = SLOT_MIN_TENS;
        default:       slot_d = SLOT_SEC_ONES;
      endcase
    end
  end

  // Frame snapshot: taken on entry to slot 0 and once right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_min     <= '0;
      snap_sec     <= '0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (load_pending || (tick && slot_q == SLOT_MIN_TENS)) begin
        snap_min <= mins_s;
        snap_sec <= secs_s;
      end
    end
  end

  // Blink timebase: free-runs only in adjust mode, otherwise parked visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (!adj_s) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end

  // Next display word for the current slot: digit decode, blanking and blink masking.
  always_comb begin
    val     = slot_q[1] ? snap_min : snap_sec;
    illegal = (val > 6'd59);
    digit   = slot_q[0] ? tens_of(val) : ones_of(val);
    seg_n   = illegal ? 7'h40 : seg_of(digit);
    hide    = adj_s && phase && (slot_q[1] == ~sel_s);
    an_n    = (blank || hide) ? 4'b0000 : (4'b0001 << slot_q);
  end

  // Output registers with polarity applied; the decimal point follows slot 2's anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= {4{COMMON_ANODE}};
      seg <= {7{COMMON_ANODE}};
      dp  <= COMMON_ANODE;
    end else begin
      an  <= an_n ^ {4{COMMON_ANODE}};
      seg <= seg_n ^ {7{COMMON_ANODE}};
      dp  <= an_n[2] ^ COMMON_ANODE;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with a short refresh and blink period.
// Outputs are sampled on the falling edge; k counts rising edges since reset release.
module tb_stopwatch_display;

  logic       clk;
  logic       rst;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_tests;
  int n_fail;

  stopwatch_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16),
    .COMMON_ANODE(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mins(mins),
    .secs(secs),
    .adj (adj),
    .sel (sel),
    .an  (an),
    .seg (seg),
    .dp  (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low anode pattern per slot, slot 0 = seconds ones.
  logic [3:0] an_tab [4];
  initial an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic do_reset(input logic [5:0] m, input logic [5:0] s,
                          input logic a, input logic sl);
    mins = m;
    secs = s;
    adj  = a;
    sel  = sl;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mins = 6'd12; secs = 6'd34; adj = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1", an, seg, dp);
    end
    do_reset(6'd12, 6'd34, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (an !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_blank: an=%b expected 1111", an);
    end
    @(negedge clk);
    n_tests++;
    if (an !== 4'b1110 || seg !== 7'h19) begin
      n_fail++;
      $display("FAIL reset_first_slot: an=%b seg=%h expected an=1110 seg=19", an, seg);
    end
    // Mid-scan asynchronous reset.
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1", an, seg, dp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (an !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_restart_blank: an=%b expected 1111", an);
    end
    @(negedge clk);
    n_tests++;
    if (an !== 4'b1110 || seg !== 7'h19) begin
      n_fail++;
      $display("FAIL reset_restart_slot0: an=%b seg=%h expected an=1110 seg=19", an, seg);
    end
  endtask

  task automatic test_scan;
    logic [6:0] seg_tab [4];
    seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};  // 4, 3, 2, 1
    do_reset(6'd12, 6'd34, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      int slot;
      @(negedge clk);
      slot = ((k - 1) / 4) % 4;
      n_tests++;
      if ((k - 1) % 4 == 0) begin
        if (an !== 4'b1111 || dp !== 1'b1) begin
          n_fail++;
          $display("FAIL scan_blank k=%0d: an=%b dp=%b expected an=1111 dp=1", k, an, dp);
        end
      end else begin
        if (an !== an_tab[slot] || seg !== seg_tab[slot] || dp !== (slot != 2)) begin
          n_fail++;
          $display("FAIL scan k=%0d: an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                   k, an, seg, dp, an_tab[slot], seg_tab[slot], slot != 2);
        end
      end
    end
  endtask

  task automatic test_tearing;
    do_reset(6'd12, 6'd34, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      int slot;
      logic [6:0] exp_seg;
      @(negedge clk);
      slot = ((k - 1) / 4) % 4;
      case (slot)
        0:       exp_seg = (k <= 16) ? 7'h19 : 7'h12;  // 4 then 5
        1:       exp_seg = (k <= 16) ? 7'h30 : 7'h19;  // 3 then 4
        2:       exp_seg = 7'h24;
        default: exp_seg = 7'h79;
      endcase
      if ((k - 1) % 4 != 0) begin
        n_tests++;
        if (an !== an_tab[slot] || seg !== exp_seg) begin
          n_fail++;
          $display("FAIL tearing k=%0d: an=%b seg=%h expected an=%b seg=%h",
                   k, an, seg, an_tab[slot], exp_seg);
        end
      end
      if (k == 2) secs = 6'd45;
    end
  endtask

  task automatic test_clamp_wrap;
    do_reset(6'd12, 6'd63, 1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      int slot;
      logic [6:0] exp_seg;
      @(negedge clk);
      slot = ((k - 1) / 4) % 4;
      if (slot == 2)      exp_seg = 7'h24;
      else if (slot == 3) exp_seg = 7'h79;
      else if (k <= 16)   exp_seg = 7'h3F;            // dash for 63
      else if (k <= 32)   exp_seg = (slot == 0) ? 7'h10 : 7'h12;  // 59
      else                exp_seg = 7'h40;            // 00
      if ((k - 1) % 4 != 0) begin
        n_tests++;
        if (an !== an_tab[slot] || seg !== exp_seg) begin
          n_fail++;
          $display("FAIL clamp_wrap k=%0d: an=%b seg=%h expected an=%b seg=%h",
                   k, an, seg, an_tab[slot], exp_seg);
        end
      end
      if (k == 2)  secs = 6'd59;
      if (k == 25) secs = 6'd0;
    end
  endtask

  task automatic test_blink;
    do_reset(6'd12, 6'd34, 1'b1, 1'b1);
    for (int k = 1; k <= 96; k++) begin
      int slot;
      logic hid_phase;
      logic in_pair;
      logic [3:0] exp_an;
      @(negedge clk);
      slot      = ((k - 1) / 4) % 4;
      hid_phase = (((k - 1) / 16) % 2 == 1) && (k < 87);
      in_pair   = (k <= 64) ? (slot < 2) : (slot >= 2);
      if ((k - 1) % 4 == 0)         exp_an = 4'b1111;
      else if (hid_phase && in_pair) exp_an = 4'b1111;
      else                           exp_an = an_tab[slot];
      if (k < 85 || k >= 87) begin
        n_tests++;
        if (an !== exp_an || dp !== exp_an[2]) begin
          n_fail++;
          $display("FAIL blink k=%0d: an=%b dp=%b expected an=%b dp=%b",
                   k, an, dp, exp_an, exp_an[2]);
        end
      end
      if (k == 64) sel = 1'b0;
      if (k == 84) adj = 1'b0;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; mins = '0; secs = '0; adj = 1'b0; sel = 1'b0;
    test_reset;
    test_scan;
    test_tearing;
    test_clamp_wrap;
    test_blink;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
